// File: rtl/fetch_unit.sv
// fetch_unit: pc/ir fetch stage (clk, rst active-low; ins_addr/ins_in memory side; br_taken/br_target/halt control; dec_ready/ir/ir_pc/ir_valid decode side; halted, fetch_count status)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_INC = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ins_addr,
  input  logic [31:0] ins_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt,
  input  logic        dec_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, ir_n, ir_pc_n, fetch_count_n;
  logic ir_valid_n, slot_free;
  assign ins_addr = pc;
  assign halted = state == HALTED;
  assign slot_free = !ir_valid || dec_ready;
  always_comb begin
    state_n = state;
    pc_n = pc;
    ir_n = ir;
    ir_pc_n = ir_pc;
    ir_valid_n = ir_valid;
    fetch_count_n = fetch_count;
    if (state == RUN) begin
      if (halt) begin
        state_n = HALTED;
        ir_valid_n = 1'b0;
      end else if (br_taken) begin
        pc_n = br_target;
        ir_valid_n = 1'b0;
      end else if (slot_free) begin
        ir_n = ins_in;
        ir_pc_n = pc;
        ir_valid_n = 1'b1;
        pc_n = pc + PC_INC;
        fetch_count_n = fetch_count + 32'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      pc <= RESET_PC;
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ir <= ir_n;
      ir_pc <= ir_pc_n;
      ir_valid <= ir_valid_n;
      fetch_count <= fetch_count_n;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed checks of fetch_unit against a behavioural model
module tb_fetch_unit;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, br_taken, halt, dec_ready, ir_valid, halted;
  logic [31:0] ins_addr, ins_in, br_target, ir, ir_pc, fetch_count;
  logic w_rst, w_ir_valid, w_halted;
  logic [31:0] w_ins_addr, w_ins_in, w_ir, w_ir_pc, w_fetch_count;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc, m_ir, m_ir_pc, m_cnt;
  logic m_v, m_h;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction
  assign ins_in = mem(ins_addr);
  assign w_ins_in = mem(w_ins_addr);
  fetch_unit u_dut (
    .clk(clk), .rst(rst), .ins_addr(ins_addr), .ins_in(ins_in), .br_taken(br_taken),
    .br_target(br_target), .halt(halt), .dec_ready(dec_ready), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .halted(halted), .fetch_count(fetch_count)
  );
  fetch_unit #(.RESET_PC(32'hFFFFFFFF)) u_wrap (
    .clk(clk), .rst(w_rst), .ins_addr(w_ins_addr), .ins_in(w_ins_in), .br_taken(1'b0),
    .br_target(32'd0), .halt(1'b0), .dec_ready(1'b1), .ir(w_ir), .ir_pc(w_ir_pc),
    .ir_valid(w_ir_valid), .halted(w_halted), .fetch_count(w_fetch_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      m_pc = 32'd0; m_ir = 32'd0; m_ir_pc = 32'd0; m_v = 0; m_cnt = 32'd0; m_h = 0;
    end else if (!m_h) begin
      if (halt) begin
        m_h = 1; m_v = 0;
      end else if (br_taken) begin
        m_pc = br_target; m_v = 0;
      end else if (!m_v || dec_ready) begin
        m_ir = mem(m_pc); m_ir_pc = m_pc; m_v = 1; m_pc = m_pc + 32'd1; m_cnt = m_cnt + 32'd1;
      end
    end
    #1;
    chk("ins_addr", ins_addr, m_pc);
    chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_v});
    chk("halted", {31'd0, halted}, {31'd0, m_h});
    chk("fetch_count", fetch_count, m_cnt);
    chk("ir", ir, m_ir);
    chk("ir_pc", ir_pc, m_ir_pc);
  endtask
  initial begin
    rst = 0; w_rst = 0; br_taken = 0; halt = 0; dec_ready = 0; br_target = 0;
    step(); step();
    chk("reset_valid", {31'd0, ir_valid}, 32'd0);
    chk("reset_count", fetch_count, 32'd0);
    chk("reset_pc", ins_addr, 32'd0);
    rst = 1; w_rst = 1; dec_ready = 1;
    step();
    chk("wrap_first_pc", w_ir_pc, 32'hFFFFFFFF);
    chk("first_ir", ir, mem(32'd0));
    step();
    chk("wrap_next_pc", w_ir_pc, 32'd0);
    step(); step();
    chk("line_ir_pc", ir_pc, 32'd3);
    chk("line_ir", ir, mem(32'd3));
    chk("line_count", fetch_count, 32'd4);
    rst = 0; step(); rst = 1;
    step(); step();
    dec_ready = 0;
    repeat (3) step();
    chk("stall_ir_pc", ir_pc, 32'd1);
    chk("stall_pc", ins_addr, 32'd2);
    chk("stall_count", fetch_count, 32'd2);
    dec_ready = 1; step();
    chk("resume_ir", ir, mem(32'd2));
    dec_ready = 0; br_taken = 1; br_target = 32'd40; step();
    chk("br_flush", {31'd0, ir_valid}, 32'd0);
    chk("br_pc", ins_addr, 32'd40);
    br_taken = 0; step();
    chk("br_ir_pc", ir_pc, 32'd40);
    chk("br_ir", ir, mem(32'd40));
    rst = 0; step(); rst = 1; dec_ready = 1;
    repeat (7) step();
    chk("pre_halt_pc", ins_addr, 32'd7);
    halt = 1; br_taken = 1; br_target = 32'd99; step();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, ir_valid}, 32'd0);
    chk("halt_pc", ins_addr, 32'd7);
    halt = 0;
    repeat (5) begin
      br_taken = 1'($urandom); dec_ready = 1'($urandom); br_target = $urandom; step();
    end
    chk("halted_pc", ins_addr, 32'd7);
    chk("halted_count", fetch_count, 32'd7);
    br_taken = 0; rst = 0; step();
    chk("rh_halted", {31'd0, halted}, 32'd0);
    chk("rh_pc", ins_addr, 32'd0);
    chk("rh_count", fetch_count, 32'd0);
    rst = 1; dec_ready = 1; step();
    chk("rh_resume", {31'd0, ir_valid}, 32'd1);
    repeat (3000) begin
      rst = ($urandom_range(0, 63) != 0);
      halt = ($urandom_range(0, 99) == 0);
      br_taken = ($urandom_range(0, 7) == 0);
      br_target = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 64) : $urandom;
      dec_ready = 1'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, PC value loaded at reset.
REQ-002 SHALL have parameter PC_INC, default 32'd1, PC step per fetch (instruction store is word-addressed).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 SHALL have port ins_addr  output  32  fetch address to instruction memory; combinationally equal to pc.
REQ-006 SHALL have port ins_in  input  32  instruction word from memory; valid in the same cycle as ins_addr (combinational read).
REQ-007 SHALL have port br_taken  input  1  redirect request from execute.
REQ-008 SHALL have port br_target  input  32  redirect address, sampled when br_taken=1.
REQ-009 SHALL have port halt  input  1  stop fetching permanently until reset.
REQ-010 SHALL have port dec_ready  input  1  decode stage accepts ir this cycle.
REQ-011 SHALL have port ir  output  32  registered instruction to decode.
REQ-012 SHALL have port ir_pc  output  32  address from which ir was fetched.
REQ-013 SHALL have port ir_valid  output  1  ir/ir_pc hold a live instruction.
REQ-014 SHALL have port halted  output  1  high while in HALTED state.
REQ-015 SHALL have port fetch_count  output  32  number of instructions loaded into ir since reset.

Function
REQ-016 SHALL implement states RUN and HALTED; halted = (state == HALTED).
REQ-017 SHALL define slot_free = !ir_valid || dec_ready.
REQ-018 In RUN, with no halt and no br_taken, and slot_free: ir <= ins_in, ir_pc <= pc, ir_valid <= 1, pc <= pc + PC_INC, fetch_count <= fetch_count + 1.
REQ-019 In RUN, with no halt and no br_taken, and !slot_free: pc, ir, ir_pc, ir_valid, fetch_count SHALL hold (stall).
REQ-020 br_taken=1 in RUN (halt=0): pc <= br_target, ir_valid <= 0 (flush), regardless of dec_ready; ir, ir_pc, fetch_count hold; first fetch from br_target occurs the following cycle.
REQ-021 halt=1 in RUN: state <= HALTED, ir_valid <= 0, pc holds; halt SHALL take priority over br_taken and dec_ready in the same cycle.
REQ-022 In HALTED: pc, ir, ir_pc, fetch_count hold, ir_valid stays 0; br_taken, halt, dec_ready ignored; exit only via reset.
REQ-023 pc + PC_INC SHALL wrap modulo 2^32; fetch_count SHALL wrap modulo 2^32.
REQ-024 Fetch latency: instruction at address A appears on ir with ir_valid=1 one clock after pc=A with slot_free.
REQ-025 Sustained throughput SHALL be one instruction per cycle while dec_ready=1.

Reset
REQ-026 On rising clk with rst=0: pc <= RESET_PC, ir <= 0, ir_pc <= 0, ir_valid <= 0, fetch_count <= 0, state <= RUN; overrides all other inputs.
REQ-027 Reset asserted mid-stall, mid-redirect or in HALTED SHALL give the same result as REQ-026; the first fetch from RESET_PC occurs in the first cycle with rst=1.

Verification
REQ-028 Straight-line: reset, mem[0..3]=I0..I3, dec_ready=1 -> ir=I0,I1,I2,I3 on 4 consecutive cycles, ir_pc=0,1,2,3, fetch_count=4.
REQ-029 Stall: ir=I1 valid, dec_ready=0 for 3 cycles -> ir=I1, pc=2, fetch_count=2 held; dec_ready=1 -> ir=I2 next cycle.
REQ-030 Branch: br_taken=1, br_target=32'd40 while ir valid and dec_ready=0 -> next cycle ir_valid=0, pc=40; following cycle ir=mem[40], ir_pc=40.
REQ-031 Halt priority: halt=1 and br_taken=1 same cycle at pc=7 -> halted=1, ir_valid=0, pc=7; further br_taken/dec_ready pulses change nothing.
REQ-032 Wrap: RESET_PC=32'hFFFFFFFF -> first ir_pc=32'hFFFFFFFF, next ir_pc=0.
REQ-033 Reset from HALTED: rst=0 one cycle -> halted=0, pc=RESET_PC, ir_valid=0, fetch_count=0; fetch resumes next cycle.
